// File: rtl/alu24_muldiv_seq_if.sv
// Bus between the control unit, the shared 24-bit ALU and the mul/div sequencer.
// Handshake: Start is a one-cycle request taken only while Busy is low;
// Done pulses once per accepted request, and results stay valid until the next accepted Start.
interface alu24_muldiv_seq_if;
    logic        Start;
    logic        OpDiv;
    logic [23:0] OperandA;
    logic [23:0] OperandB;
    logic        Busy;
    logic        Done;
    logic [23:0] ResultHi;
    logic [23:0] ResultLo;
    logic        DivZero;
    logic [23:0] AluA;
    logic [23:0] AluB;
    logic        AluBNegate;
    logic [1:0]  AluOp;
    logic [23:0] AluResult;
    logic        AluCarryOut;
    logic [1:0]  DbgState;

    modport master (
        output Start, OpDiv, OperandA, OperandB, AluResult, AluCarryOut,
        input  Busy, Done, ResultHi, ResultLo, DivZero,
        input  AluA, AluB, AluBNegate, AluOp, DbgState
    );

    modport slave (
        input  Start, OpDiv, OperandA, OperandB, AluResult, AluCarryOut,
        output Busy, Done, ResultHi, ResultLo, DivZero,
        output AluA, AluB, AluBNegate, AluOp, DbgState
    );
endinterface

// File: rtl/alu24_muldiv_seq.sv
// Sequential unsigned 24x24 multiply (shift-add) and 24/24 divide (restoring),
// issuing one add/subtract per cycle to the shared ripple ALU.
module alu24_muldiv_seq (
    input  logic               Clock,
    input  logic               ResetN,
    alu24_muldiv_seq_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic        r_op_div;
    logic        r_div_zero;
    logic [23:0] r_hi;
    logic [23:0] r_lo;
    logic [23:0] r_m;

    logic [23:0] w_alu_a;
    logic [23:0] w_alu_b;
    logic        w_alu_neg;
    logic [23:0] w_t;
    logic [24:0] w_sum;
    logic [24:0] w_mul_s;
    logic        w_take;

    // Divide: shifted partial remainder; Msb set means T already exceeds any 24-bit divisor.
    assign w_t     = {r_hi[22:0], r_lo[23]};
    assign w_take  = r_hi[23] | bus.AluCarryOut;
    assign w_sum   = {bus.AluCarryOut, bus.AluResult};
    assign w_mul_s = r_lo[0] ? w_sum : {1'b0, r_hi};

    always_comb begin
        w_alu_a   = 24'd0;
        w_alu_b   = 24'd0;
        w_alu_neg = 1'b0;
        if (r_state == S_RUN) begin
            if (r_op_div) begin
                w_alu_a   = w_t;
                w_alu_b   = r_m;
                w_alu_neg = 1'b1;
            end else begin
                w_alu_a   = r_hi;
                w_alu_b   = r_m;
                w_alu_neg = 1'b0;
            end
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_state    <= S_IDLE;
            r_cnt      <= 5'd0;
            r_op_div   <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= 24'd0;
            r_lo       <= 24'd0;
            r_m        <= 24'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        r_cnt      <= 5'd0;
                        r_op_div   <= bus.OpDiv;
                        r_div_zero <= 1'b0;
                        if (!bus.OpDiv) begin
                            r_hi    <= 24'd0;
                            r_lo    <= bus.OperandB;
                            r_m     <= bus.OperandA;
                            r_state <= S_RUN;
                        end else if (bus.OperandB == 24'd0) begin
                            r_hi       <= bus.OperandA;
                            r_lo       <= 24'hFFFFFF;
                            r_m        <= 24'd0;
                            r_div_zero <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_hi    <= 24'd0;
                            r_lo    <= bus.OperandA;
                            r_m     <= bus.OperandB;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (r_op_div) begin
                        if (w_take) begin
                            r_hi <= bus.AluResult;
                            r_lo <= {r_lo[22:0], 1'b1};
                        end else begin
                            r_hi <= w_t;
                            r_lo <= {r_lo[22:0], 1'b0};
                        end
                    end else begin
                        r_hi <= w_mul_s[24:1];
                        r_lo <= {w_mul_s[0], r_lo[23:1]};
                    end
                    if (r_cnt == 5'd23) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Busy       = (r_state != S_IDLE);
    assign bus.Done       = (r_state == S_DONE);
    assign bus.ResultHi   = r_hi;
    assign bus.ResultLo   = r_lo;
    assign bus.DivZero    = r_div_zero;
    assign bus.AluA       = w_alu_a;
    assign bus.AluB       = w_alu_b;
    assign bus.AluBNegate = w_alu_neg;
    assign bus.AluOp      = 2'b10;
    assign bus.DbgState   = r_state;
endmodule

// File: tb/tb_alu24_muldiv_seq.sv
// Directed bench for alu24_muldiv_seq: expected results are queued at issue time
// and matched against each Done pulse by an independent monitor.
module tb_alu24_muldiv_seq;
    localparam int W = 65;

    logic        clk;
    logic        rst_n;
    logic [15:0] cyc;
    int          checks;
    int          failures;
    logic [W-1:0] exp_q[$];

    alu24_muldiv_seq_if bus();

    alu24_muldiv_seq dut (
        .Clock  (clk),
        .ResetN (rst_n),
        .bus    (bus.slave)
    );

    // ALU model: add, or subtract via inverted B plus carry-in.
    logic [23:0] alu_b_eff;
    assign alu_b_eff = bus.AluBNegate ? ~bus.AluB : bus.AluB;
    assign {bus.AluCarryOut, bus.AluResult} =
        {1'b0, bus.AluA} + {1'b0, alu_b_eff} + {24'd0, bus.AluBNegate};

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (!rst_n) cyc <= 16'd0;
        else        cyc <= cyc + 16'd1;
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // driver: issue one request and queue its expected outcome
    task automatic do_start(input logic op_div, input logic [23:0] a, input logic [23:0] b,
                            input logic [23:0] e_hi, input logic [23:0] e_lo,
                            input logic e_dz, input int lat);
        @(negedge clk);
        bus.Start    = 1'b1;
        bus.OpDiv    = op_div;
        bus.OperandA = a;
        bus.OperandB = b;
        exp_q.push_back({e_hi, e_lo, e_dz, cyc + 16'(lat)});
        @(negedge clk);
        bus.Start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!bus.Busy && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (ok == 0) begin
            failures++;
            $display("FAIL %s_timeout actual=busy_or_pending expected=idle", name);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_n && bus.Done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=done expected=no_done");
            end else begin
                e = exp_q.pop_front();
                chk("result_hi", {24'd0, bus.ResultHi}, {24'd0, e[64:41]});
                chk("result_lo", {24'd0, bus.ResultLo}, {24'd0, e[40:17]});
                chk("div_zero",  {47'd0, bus.DivZero},  {47'd0, e[16]});
                chk("done_cycle", {32'd0, cyc}, {32'd0, e[15:0]});
            end
        end
    end

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.Start    = 1'b0;
        bus.OpDiv    = 1'b0;
        bus.OperandA = 24'd0;
        bus.OperandB = 24'd0;
        repeat (3) @(negedge clk);

        chk("rst_busy",   {47'd0, bus.Busy},       48'd0);
        chk("rst_done",   {47'd0, bus.Done},       48'd0);
        chk("rst_hi",     {24'd0, bus.ResultHi},   48'd0);
        chk("rst_lo",     {24'd0, bus.ResultLo},   48'd0);
        chk("rst_dz",     {47'd0, bus.DivZero},    48'd0);
        chk("rst_alu_a",  {24'd0, bus.AluA},       48'd0);
        chk("rst_alu_b",  {24'd0, bus.AluB},       48'd0);
        chk("rst_alu_neg",{47'd0, bus.AluBNegate}, 48'd0);
        chk("rst_alu_op", {46'd0, bus.AluOp},      48'd2);
        chk("rst_state",  {46'd0, bus.DbgState},   48'd0);
        rst_n = 1'b1;

        do_start(1'b0, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE, 24'h000001, 1'b0, 25);
        wait_idle("mul_max");
        do_start(1'b0, 24'h000123, 24'h000000, 24'h000000, 24'h000000, 1'b0, 25);
        wait_idle("mul_zero");
        do_start(1'b0, 24'hABCDEF, 24'h000010, 24'h00000A, 24'hBCDEF0, 1'b0, 25);
        wait_idle("mul_shift");

        do_start(1'b1, 24'd100, 24'd7, 24'd2, 24'd14, 1'b0, 25);
        repeat (3) @(negedge clk);
        chk("run_alu_neg", {47'd0, bus.AluBNegate}, 48'd1);
        chk("run_alu_b",   {24'd0, bus.AluB},       48'd7);
        chk("run_alu_op",  {46'd0, bus.AluOp},      48'd2);
        wait_idle("div_100_7");
        chk("idle_alu_a",  {24'd0, bus.AluA},       48'd0);

        do_start(1'b1, 24'hFFFFFF, 24'h000001, 24'h000000, 24'hFFFFFF, 1'b0, 25);
        wait_idle("div_by_one");
        do_start(1'b1, 24'h800000, 24'hFFFFFF, 24'h800000, 24'h000000, 1'b0, 25);
        wait_idle("div_msb");
        do_start(1'b1, 24'h123456, 24'h000100, 24'h000056, 24'h001234, 1'b0, 25);
        wait_idle("div_shift");

        do_start(1'b1, 24'h001234, 24'h000000, 24'h001234, 24'hFFFFFF, 1'b1, 1);
        wait_idle("div_zero");
        do_start(1'b0, 24'd3, 24'd5, 24'd0, 24'd15, 1'b0, 25);
        wait_idle("mul_after_dz");

        // Start pulses in RUN and in DONE must be ignored
        do_start(1'b0, 24'h000ABC, 24'h000011, 24'd0, 24'h00B67C, 1'b0, 25);
        repeat (4) @(negedge clk);
        bus.Start = 1'b1; bus.OpDiv = 1'b1; bus.OperandA = 24'd5; bus.OperandB = 24'd5;
        @(negedge clk);
        bus.Start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.Done) break;
            @(negedge clk);
        end
        bus.Start = 1'b1; bus.OpDiv = 1'b0; bus.OperandA = 24'd9; bus.OperandB = 24'd9;
        @(negedge clk);
        bus.Start = 1'b0;
        wait_idle("ignore_start");
        repeat (3) @(negedge clk);
        chk("ignore_busy", {47'd0, bus.Busy},     48'd0);
        chk("ignore_lo",   {24'd0, bus.ResultLo}, 48'h00B67C);
        chk("ignore_dz",   {47'd0, bus.DivZero},  48'd0);

        // asynchronous abort in the middle of RUN
        do_start(1'b0, 24'h000777, 24'h000333, 24'd0, 24'd0, 1'b0, 25);
        repeat (10) @(posedge clk);
        #2;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {47'd0, bus.Busy},     48'd0);
        chk("abort_done", {47'd0, bus.Done},     48'd0);
        chk("abort_hi",   {24'd0, bus.ResultHi}, 48'd0);
        chk("abort_lo",   {24'd0, bus.ResultLo}, 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_start(1'b0, 24'd6, 24'd7, 24'd0, 24'd42, 1'b0, 25);
        wait_idle("mul_after_abort");

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu24_muldiv_seq.md
# alu24_muldiv_seq

Multi-cycle sequencer that computes unsigned 24×24 multiply (48-bit product) and unsigned 24/24 divide (quotient + remainder) by driving the shared 24-bit ripple ALU one add/subtract per cycle. It sits between the control unit and the ALU's operand/control ports. A multiplexer outside this block hands the ALU to this sequencer while Busy is high. The datapath is shift-add for multiply and restoring for divide.

## Interface
- No parameters; width fixed at 24.
- Clock  in  1  rising-edge clock
- ResetN  in  1  asynchronous, active-low reset
- Start  in  1  one-cycle request; sampled only in IDLE
- OpDiv  in  1  0 = multiply, 1 = divide; sampled with Start
- OperandA  in  24  multiplicand / dividend
- OperandB  in  24  multiplier / divisor
- Busy  out  1  operation in progress
- Done  out  1  one-cycle pulse; results valid from this cycle on
- ResultHi  out  24  product[47:24] / remainder
- ResultLo  out  24  product[23:0] / quotient
- DivZero  out  1  last divide had divisor 0
- AluA, AluB  out  24  ALU operands
- AluBNegate  out  1  ALU subtract select; also drives the ALU carry-in
- AluOp  out  2  ALU function; always 2'b10 (add/sub)
- AluResult  in  24  ALU sum
- AluCarryOut  in  1  ALU carry out of bit 23

## Operation
- States: IDLE → RUN → DONE → IDLE. A 5-bit iteration counter Cnt counts 0..23.
- IDLE, Start=1:
  - Latch OperandA and OperandB; clear DivZero; Cnt=0.
  - Multiply: Hi=0, Lo=OperandB (multiplier), M=OperandA. Go to RUN.
  - Divide with OperandB≠0: R=0, Q=OperandA, D=OperandB. Go to RUN.
  - Divide with OperandB=0: go straight to DONE. ResultLo=24'hFFFFFF, ResultHi=OperandA, DivZero=1.
- RUN, multiply iteration:
  - ALU inputs: AluA=Hi, AluB=M, AluBNegate=0.
  - S = Lo[0] ? {AluCarryOut, AluResult} : {1'b0, Hi}.
  - {Hi, Lo} ← {S, Lo[23:1]}, a 49-bit shift right by 1.
- RUN, divide iteration:
  - Shift: T={R[22:0], Q[23]}; save Msb=R[23].
  - ALU inputs: AluA=T, AluB=D, AluBNegate=1.
  - If Msb | AluCarryOut: R←AluResult, Q←{Q[22:0], 1}.
  - Else: R←T, Q←{Q[22:0], 0}.
- RUN: after the iteration with Cnt=23, go to DONE; otherwise Cnt+1.
- DONE: Done=1, Busy=1, outputs updated; next state IDLE.
- ResultHi, ResultLo and DivZero hold until the next accepted Start.
- Start in RUN/DONE is ignored; no queuing.
- In IDLE/DONE the ALU outputs are AluA=0, AluB=0, AluBNegate=0; AluOp=2'b10 in every state.

## Timing
- Reset (async, ResetN=0) gives:
  - state IDLE, Cnt=0, Busy=0, Done=0, DivZero=0;
  - ResultHi=0, ResultLo=0, all internal registers 0;
  - AluA=0, AluB=0, AluBNegate=0, AluOp=2'b10.
- Reset mid-operation aborts immediately. There is no Done pulse, and results return to 0.
- Start accepted at edge E0. Busy=1 from E0. RUN occupies 24 cycles (E0..E23 → E24). Done=1 for one cycle after E24. Busy falls after E25.
- Latency from Start to Done is 25 cycles; a new Start is accepted in the cycle after Done.
- Divide-by-zero: Done is asserted one cycle after the Start edge; Busy is high for that single cycle.
- ALU path is combinational within one cycle. AluResult and AluCarryOut are sampled at the same edge that updates the registers.

## Test plan
- Multiply 24'hFFFFFF × 24'hFFFFFF → Done 25 cycles after Start; ResultHi=24'hFFFFFE, ResultLo=24'h000001, DivZero=0.
- Multiply 24'h000123 × 0 → ResultHi=0, ResultLo=0. Divide 100/7 → ResultLo=14, ResultHi=2.
- Divide 24'hFFFFFF / 24'h000001 → quotient 24'hFFFFFF, remainder 0. Divide 24'h800000 / 24'hFFFFFF → quotient 0, remainder 24'h800000. These exercise the Msb path.
- Divide 24'h001234 / 0 → Done one cycle after Start; DivZero=1, ResultLo=24'hFFFFFF, ResultHi=24'h001234. A following multiply 3×5 clears DivZero and gives ResultLo=15.
- Start pulses during RUN and during the DONE cycle with different operands → ignored; the first operation's results are unchanged and exactly one Done pulse occurs.
- Drop ResetN at RUN cycle 10 → Busy, Done and results go to 0 asynchronously. After release, IDLE accepts a new Start, and 6×7 gives ResultLo=42.
